// File: rtl/conc_stim_player_pkg.sv
// Shared types and opcode field helpers for the stimulus replay engine.
// Field offsets are relative: rep sits above the data lane, flags above rep.
package conc_stim_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int REP_LSB  = 0;
    localparam int DISP_BIT = 0;
    localparam int OBS_BIT  = 1;
    localparam int LAST_BIT = 2;

    // Opcodes are widened to this before extraction so one set of helpers serves any DATA_W/REP_W.
    localparam int OP_MAX_W = 128;
    typedef logic [OP_MAX_W-1:0] op_max_t;

    function automatic op_max_t field_mask(input int w);
        return (op_max_t'(1) << w) - op_max_t'(1);
    endfunction

    function automatic logic op_bit(input op_max_t op, input int pos);
        op_max_t t;
        t = op >> pos;
        return t[0];
    endfunction

    function automatic op_max_t op_data(input op_max_t op, input int dw);
        return op & field_mask(dw);
    endfunction

    function automatic op_max_t op_rep(input op_max_t op, input int dw, input int rw);
        return (op >> (dw + REP_LSB)) & field_mask(rw);
    endfunction

    function automatic logic op_disp(input op_max_t op, input int dw, input int rw);
        return op_bit(op, dw + rw + DISP_BIT);
    endfunction

    function automatic logic op_obs(input op_max_t op, input int dw, input int rw);
        return op_bit(op, dw + rw + OBS_BIT);
    endfunction

    function automatic logic op_last(input op_max_t op, input int dw, input int rw);
        return op_bit(op, dw + rw + LAST_BIT);
    endfunction

endpackage

// File: rtl/conc_stim_player_if.sv
// Loader/control side and stimulus/status side of the replay engine.
// master = harness (loader + DUT-facing consumer), slave = the player.
interface conc_stim_player_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int REP_W  = 8
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int OP_W   = DATA_W + REP_W + 3;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [OP_W-1:0]   wr_data;
    logic              start;
    logic              loop_en;
    logic              pause;
    logic              abort;
    logic [DATA_W-1:0] stim_data;
    logic              stim_display;
    logic              stim_obs;
    logic              stim_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;
    logic [31:0]       beat_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, start, loop_en, pause, abort,
        input  stim_data, stim_display, stim_obs, stim_valid, pc, busy, done, beat_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, loop_en, pause, abort,
        output stim_data, stim_display, stim_obs, stim_valid, pc, busy, done, beat_cnt
    );
endinterface

// File: rtl/conc_stim_player_ram.sv
// Opcode program store: one synchronous write port, one asynchronous read port.
// Contents survive reset; the player reads the next entry combinationally.
module conc_stim_ram #(
    parameter int DEPTH  = 16,
    parameter int OP_W   = 43,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [OP_W-1:0]   i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [OP_W-1:0]   o_rd_data
);
    logic [OP_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/conc_stim_player.sv
// Stimulus replay engine: plays a preloaded opcode program one beat per clock.
// Start-to-first-beat 1 cycle, no bubbles between entries; pause freezes beats in place.
module conc_stim_player
    import conc_stim_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int REP_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    conc_stim_player_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int OP_W   = DATA_W + REP_W + 3;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [REP_W-1:0]  r_rep;
    logic [31:0]       r_beat;
    logic [DATA_W-1:0] r_data;
    logic              r_disp;
    logic              r_obs;
    logic              r_last;
    logic              r_valid;
    logic              r_done;

    logic              w_not_run;
    logic              w_final;
    logic              w_abort;
    logic              w_we;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [OP_W-1:0]   w_rd_op;
    op_max_t           w_op;

    assign w_not_run = (r_state != S_RUN);
    assign w_final   = r_last || (r_pc == ADDR_W'(DEPTH - 1));
    assign w_abort   = bus.abort && (r_state != S_IDLE);
    assign w_we      = bus.wr_en && w_not_run && !bus.start;
    // The only entry ever fetched is the one loaded at the next edge: 0 on start/wrap, else pc+1.
    assign w_rd_addr = (w_not_run || w_final) ? '0 : r_pc + ADDR_W'(1);
    assign w_op      = op_max_t'(w_rd_op);

    conc_stim_ram #(
        .DEPTH  (DEPTH),
        .OP_W   (OP_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_we),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_op)
    );

    always_ff @(posedge clk) begin
        if (!reset || w_abort) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_rep   <= '0;
            r_beat  <= '0;
            r_data  <= '0;
            r_disp  <= 1'b0;
            r_obs   <= 1'b0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (!bus.pause) begin
                if (r_rep != '0) begin
                    r_rep <= r_rep - REP_W'(1);
                    if (r_beat != '1) r_beat <= r_beat + 32'd1;
                end else if (w_final && !bus.loop_en) begin
                    r_state <= S_DONE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_pc   <= w_rd_addr;
                    r_rep  <= REP_W'(op_rep(w_op, DATA_W, REP_W));
                    r_data <= DATA_W'(op_data(w_op, DATA_W));
                    r_disp <= op_disp(w_op, DATA_W, REP_W);
                    r_obs  <= op_obs(w_op, DATA_W, REP_W);
                    r_last <= op_last(w_op, DATA_W, REP_W);
                    if (r_beat != '1) r_beat <= r_beat + 32'd1;
                end
            end
        end else if (bus.start) begin
            r_state <= S_RUN;
            r_pc    <= w_rd_addr;
            r_rep   <= REP_W'(op_rep(w_op, DATA_W, REP_W));
            r_data  <= DATA_W'(op_data(w_op, DATA_W));
            r_disp  <= op_disp(w_op, DATA_W, REP_W);
            r_obs   <= op_obs(w_op, DATA_W, REP_W);
            r_last  <= op_last(w_op, DATA_W, REP_W);
            r_beat  <= 32'd1;
            r_valid <= 1'b1;
            r_done  <= 1'b0;
        end
    end

    assign bus.stim_data    = r_data;
    assign bus.stim_display = r_disp;
    assign bus.stim_obs     = r_obs;
    assign bus.stim_valid   = r_valid;
    assign bus.pc           = r_pc;
    assign bus.busy         = (r_state == S_RUN);
    assign bus.done         = r_done;
    assign bus.beat_cnt     = r_beat;
endmodule

// File: doc/conc_stim_player.md
# conc_stim_player

Synthesizable, parametrised stimulus replay engine for concolic test harnesses. It plays a preloaded opcode program into a DUT, one beat per clock, driving the data, display and observation lanes. Compared with a free-running program counter, it adds per-entry repeat counts, explicit end-of-program marking, optional looping, pause and abort, and a start/done handshake. It sits between the harness loader and the DUT top.

## Interface
- DATA_W, 32, width of the stimulus data lane
- DEPTH, 16, number of opcode entries (≥2)
- REP_W, 8, width of the per-entry repeat field
- ADDR_W, $clog2(DEPTH), program-counter width (derived)
- OP_W, DATA_W+REP_W+3, opcode width (derived)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- wr_en  in  1  program-write strobe
- wr_addr  in  ADDR_W  program-write address
- wr_data  in  OP_W  opcode; bit OP_W-1=last, OP_W-2=obs, OP_W-3=display, [DATA_W+REP_W-1:DATA_W]=rep, [DATA_W-1:0]=data
- start  in  1  begin playback (pulse)
- loop_en  in  1  restart at entry 0 after the last entry
- pause  in  1  freeze playback
- abort  in  1  stop playback and return to IDLE
- stim_data  out  DATA_W  data lane to the DUT
- stim_display  out  1  display lane
- stim_obs  out  1  observation lane
- stim_valid  out  1  a beat is being driven this cycle
- pc  out  ADDR_W  index of the current entry
- busy  out  1  in RUN
- done  out  1  playback completed (level)
- beat_cnt  out  32  beats emitted since start; saturates at all-ones

## Operation
- States: IDLE, RUN, DONE.
- Reset (reset=0 at an edge): state IDLE. All outputs are 0. Program memory is not cleared.
- Writes are accepted only in IDLE and DONE. In RUN, wr_en is ignored.
- start in IDLE or DONE:
  - Next cycle: state RUN, pc=0, entry 0 on the outputs, stim_valid=1.
  - Repeat counter loads entry 0's rep; done clears; beat_cnt=1.
- A write in the same cycle as start is ignored; start has priority.
- start while in RUN is ignored.
- RUN beat rules:
  - Each entry is driven for rep+1 consecutive unpaused cycles. rep=0 means one cycle.
  - An entry ends when its repeat counter reaches 0.
  - It is the final entry if last=1 or pc==DEPTH-1.
- At the end of a non-final entry: pc increments and the next entry is presented the following cycle, with no bubble.
- At the end of the final entry:
  - If loop_en=1: pc wraps to 0 with no bubble. loop_en is sampled at that cycle.
  - Otherwise: next cycle state DONE, stim_valid=0, done=1. stim_data, stim_display and stim_obs hold their last values.
- pause=1 in RUN:
  - The repeat counter, pc and beat_cnt hold. Outputs hold and stim_valid stays 1.
  - The paused cycle does not count as a beat.
- abort in RUN or DONE: next cycle state IDLE, all outputs 0, done=0.
  - abort beats pause and start in the same cycle.
  - abort in IDLE has no effect.
- beat_cnt increments once per unpaused RUN cycle. It saturates and never wraps.

## Timing
- start to first valid beat: 1 cycle.
- Non-looping program runtime: Σ(rep_i+1) valid cycles over entries 0..final. done rises on the cycle after the final beat.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Program memory has an asynchronous read into the output registers. A write becomes visible to the next start.
- busy = (state==RUN). done is a registered level.

## Structure
- Package conc_stim_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - field-offset localparams (LAST_BIT, OBS_BIT, DISP_BIT, REP_LSB);
  - field-extract functions parametrised by DATA_W/REP_W.
- Sub-module conc_stim_ram: DEPTH×OP_W, one synchronous write port, one asynchronous read port, no reset.
- The top level contains the FSM, repeat counter, pc, beat counter and output registers.

## Test plan
- Basic program: entries 0..2, data 0xA,0xB,0xC, rep=0, last set on entry 2, loop_en=0. After start, expect stim_data A,B,C on 3 consecutive cycles, then done=1, stim_valid=0, stim_data holding 0xC.
- Repeat: entry 0 with rep=3, data 0x55; entry 1 with last=1, rep=0. Expect 0x55 for 4 cycles, then 1 cycle of entry 1, then done; beat_cnt=5.
- Loop and pause: 2-entry program with loop_en=1. Expect pc 0,1,0,1 with no bubble. pause for 3 cycles mid-entry: outputs and beat_cnt frozen, then playback resumes with the entry's remaining count.
- No last bit: all DEPTH entries with last=0 and loop_en=0. Expect playback to end after entry DEPTH-1, done=1.
- Priority: abort+start in the same RUN cycle, expect IDLE with outputs 0. wr_en during RUN, expect memory unchanged when read back on the next playback. reset=0 mid-RUN, expect all outputs 0 next cycle.
- Display/obs lanes: entry with display=1, obs=1. Expect stim_display and stim_obs high exactly during that entry's beats.
